// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm ring path.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int unsigned SNOOZE_MIN_DEF = 32'd5;
    localparam int unsigned RING_MAX_DEF   = 32'd10;
    localparam int unsigned BEEP_HALF_DEF  = 32'd4;
    localparam int unsigned MAX_SNOOZE_DEF = 32'd3;

endpackage

// File: rtl/alarm_ring_controller_beep_gen.sv
// Buzzer cadence divider: phase starts high on restart and toggles every BEEP_HALF
// enabled cycles; it is held low whenever the divider is not enabled.
module beep_gen
    import alarm_pkg::*;
#(
    parameter int unsigned BEEP_HALF = BEEP_HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic phase
);

    localparam int unsigned CW = $clog2(BEEP_HALF + 32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BEEP_HALF - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Half-period counter and phase flip-flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else if (restart) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b1;
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CW{1'b0}};
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm ring FSM: AA rising edge -> RING, snooze/stop buttons, minute-based snooze and ring timeout.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = SNOOZE_MIN_DEF,
    parameter int unsigned RING_MAX   = RING_MAX_DEF,
    parameter int unsigned BEEP_HALF  = BEEP_HALF_DEF,
    parameter int unsigned MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic AA,
    input  logic EN,
    input  logic MIN_TICK,
    input  logic SN,
    input  logic ST,
    output logic BZ,
    output logic RINGING,
    output logic SNOOZING,
    output logic MISSED
);

    localparam int unsigned RMW = $clog2(RING_MAX + 32'd1);
    localparam int unsigned SMW = $clog2(SNOOZE_MIN + 32'd1);
    localparam logic [RMW-1:0] RING_LAST = RMW'(RING_MAX - 32'd1);
    localparam logic [RMW-1:0] RING_SAT  = RMW'(RING_MAX);
    localparam logic [RMW-1:0] RING_ONE  = RMW'(32'd1);
    localparam logic [SMW-1:0] SNZ_LAST  = SMW'(SNOOZE_MIN - 32'd1);
    localparam logic [SMW-1:0] SNZ_SAT   = SMW'(SNOOZE_MIN);
    localparam logic [SMW-1:0] SNZ_ONE   = SMW'(32'd1);

    alarm_state_t   state_r, state_s;
    logic [RMW-1:0] ring_min_r, ring_min_s;
    logic [SMW-1:0] snz_min_r, snz_min_s;
    logic           aa_q_r;
    logic           rise_s;
    logic           sn_ok_s;
    logic           missed_s;
    logic           beep_restart_s;
    logic           beep_enable_s;
    logic           ringing_r, snoozing_r, missed_r;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int unsigned CW = $clog2(MAX_SNOOZE + 32'd1);
    localparam logic [CW-1:0] SNZ_CNT_MAX = CW'(MAX_SNOOZE);
    localparam logic [CW-1:0] SNZ_CNT_ONE = CW'(32'd1);
    logic [CW-1:0] snz_cnt_r, snz_cnt_s;

    assign sn_ok_s = (snz_cnt_r != SNZ_CNT_MAX);
`else
    // Unlimited snoozes; MAX_SNOOZE only matters in the limited build.
    if (MAX_SNOOZE == 32'd0) begin : g_max_snooze_unused
    end
    assign sn_ok_s = 1'b1;
`endif

    assign rise_s = AA & ~aa_q_r;

    // Next-state, counter updates and timeout pulse
    always_comb begin
        state_s    = state_r;
        ring_min_s = ring_min_r;
        snz_min_s  = snz_min_r;
        missed_s   = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_cnt_s  = snz_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (rise_s && EN) begin
                    state_s    = RING;
                    ring_min_s = {RMW{1'b0}};
                    snz_min_s  = {SMW{1'b0}};
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snz_cnt_s  = {CW{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RING: begin
                if (!EN || ST) begin
                    state_s = IDLE;
                end else if (SN && sn_ok_s) begin
                    state_s   = SNOOZE;
                    snz_min_s = {SMW{1'b0}};
`ifdef ALARM_SNOOZE_LIMIT_EN
                    if (snz_cnt_r != SNZ_CNT_MAX) begin
                        snz_cnt_s = snz_cnt_r + SNZ_CNT_ONE;
                    end else begin
                        snz_cnt_s = snz_cnt_r;
                    end
`endif
                end else if (MIN_TICK) begin
                    if (ring_min_r == RING_LAST) begin
                        state_s  = IDLE;
                        missed_s = 1'b1;
                    end else if (ring_min_r != RING_SAT) begin
                        ring_min_s = ring_min_r + RING_ONE;
                    end else begin
                        ring_min_s = ring_min_r;
                    end
                end else begin
                    state_s = RING;
                end
            end
            SNOOZE: begin
                if (!EN || ST) begin
                    state_s = IDLE;
                end else if (MIN_TICK) begin
                    if (snz_min_r == SNZ_LAST) begin
                        state_s    = RING;
                        ring_min_s = {RMW{1'b0}};
                    end else if (snz_min_r != SNZ_SAT) begin
                        snz_min_s = snz_min_r + SNZ_ONE;
                    end else begin
                        snz_min_s = snz_min_r;
                    end
                end else begin
                    state_s = SNOOZE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Restart cadence on every entry into RING so the buzzer always opens high
    assign beep_restart_s = (state_s == RING) && (state_r != RING);
    assign beep_enable_s  = (state_s == RING);

    // State, counters, edge-detect history and registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            ring_min_r <= {RMW{1'b0}};
            snz_min_r  <= {SMW{1'b0}};
            aa_q_r     <= 1'b0;
            ringing_r  <= 1'b0;
            snoozing_r <= 1'b0;
            missed_r   <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_cnt_r  <= {CW{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            ring_min_r <= ring_min_s;
            snz_min_r  <= snz_min_s;
            aa_q_r     <= AA;
            ringing_r  <= (state_s == RING);
            snoozing_r <= (state_s == SNOOZE);
            missed_r   <= missed_s;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_cnt_r  <= snz_cnt_s;
`endif
        end
    end

    beep_gen #(
        .BEEP_HALF (BEEP_HALF)
    ) u_beep_gen (
        .clk     (CLK),
        .rst_n   (RST_N),
        .restart (beep_restart_s),
        .enable  (beep_enable_s),
        .phase   (BZ)
    );

    assign RINGING  = ringing_r;
    assign SNOOZING = snoozing_r;
    assign MISSED   = missed_r;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed self-checking bench for alarm_ring_controller with default parameters.
module tb_alarm_ring_controller;

    logic CLK = 1'b0;
    logic RST_N, AA, EN, MIN_TICK, SN, ST;
    logic BZ, RINGING, SNOOZING, MISSED;
    logic [3:0] outs;
    int checks = 0;
    int failures = 0;

    assign outs = {RINGING, SNOOZING, BZ, MISSED};

    alarm_ring_controller dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .AA       (AA),
        .EN       (EN),
        .MIN_TICK (MIN_TICK),
        .SN       (SN),
        .ST       (ST),
        .BZ       (BZ),
        .RINGING  (RINGING),
        .SNOOZING (SNOOZING),
        .MISSED   (MISSED)
    );

    always #5 CLK = ~CLK;

    // One clock, then settle 1ns past the edge; inputs set here are seen at the next edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Output vector order: {RINGING, SNOOZING, BZ, MISSED}
    task automatic test_reset;
        RST_N = 1'b0; AA = 1'b0; EN = 1'b1; MIN_TICK = 1'b0; SN = 1'b0; ST = 1'b0;
        step(3);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", outs, 4'b0000);
        end
        RST_N = 1'b1;
        step(2);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=%b", outs, 4'b0000);
        end
    endtask

    task automatic test_ring_beep;
        logic [3:0] exp;
        AA = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            exp = {1'b1, 1'b0, ((i / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b0};
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL beep_cycle%0d got=%b exp=%b", i, outs, exp);
            end
        end
        ST = 1'b1; step(1); ST = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL stop_ring got=%b exp=%b", outs, 4'b0000);
        end
        step(3);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL held_aa_no_refire got=%b exp=%b", outs, 4'b0000);
        end
        AA = 1'b0;
        step(1);
    endtask

    task automatic test_snooze;
        AA = 1'b1; step(1); AA = 1'b0;
        step(2);
        SN = 1'b1; step(1); SN = 1'b0;
        checks++;
        if (outs !== 4'b0100) begin
            failures++;
            $display("FAIL snooze_enter got=%b exp=%b", outs, 4'b0100);
        end
        for (int t = 1; t <= 5; t++) begin
            step(2);
            MIN_TICK = 1'b1; step(1); MIN_TICK = 1'b0;
            checks++;
            if (t < 5 && outs !== 4'b0100) begin
                failures++;
                $display("FAIL snooze_tick%0d got=%b exp=%b", t, outs, 4'b0100);
            end else if (t == 5 && outs !== 4'b1010) begin
                failures++;
                $display("FAIL snooze_rering got=%b exp=%b", outs, 4'b1010);
            end
        end
        ST = 1'b1; step(1); ST = 1'b0;
        step(1);
    endtask

    task automatic test_timeout;
        AA = 1'b1; step(1); AA = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            MIN_TICK = 1'b1; step(1); MIN_TICK = 1'b0;
            checks++;
            if (t < 10 && (RINGING !== 1'b1 || MISSED !== 1'b0)) begin
                failures++;
                $display("FAIL timeout_tick%0d got=%b exp=1x0 ringing/missed", t, outs);
            end else if (t == 10 && outs !== 4'b0001) begin
                failures++;
                $display("FAIL timeout_missed got=%b exp=%b", outs, 4'b0001);
            end
            step(1);
        end
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL missed_one_cycle got=%b exp=%b", outs, 4'b0000);
        end
    endtask

    task automatic test_stop_and_snooze;
        AA = 1'b1; step(1); AA = 1'b0;
        ST = 1'b1; SN = 1'b1; step(1); ST = 1'b0; SN = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL st_sn_same got=%b exp=%b", outs, 4'b0000);
        end
        step(2);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL st_sn_stays_idle got=%b exp=%b", outs, 4'b0000);
        end
    endtask

    task automatic test_snooze_limit;
        logic [3:0] exp4;
        AA = 1'b1; step(1); AA = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            SN = 1'b1; step(1); SN = 1'b0;
            checks++;
            if (outs !== 4'b0100) begin
                failures++;
                $display("FAIL snooze%0d_enter got=%b exp=%b", s, outs, 4'b0100);
            end
            for (int t = 0; t < 5; t++) begin
                MIN_TICK = 1'b1; step(1); MIN_TICK = 1'b0;
            end
            checks++;
            if (outs !== 4'b1010) begin
                failures++;
                $display("FAIL snooze%0d_return got=%b exp=%b", s, outs, 4'b1010);
            end
        end
`ifdef ALARM_SNOOZE_LIMIT_EN
        exp4 = 4'b1000;
`else
        exp4 = 4'b0100;
`endif
        step(1);
        SN = 1'b1; step(1); SN = 1'b0;
        checks++;
        if (outs[3:2] !== exp4[3:2]) begin
            failures++;
            $display("FAIL fourth_snooze got=%b exp=%b ringing/snoozing", outs[3:2], exp4[3:2]);
        end
        ST = 1'b1; step(1); ST = 1'b0;
        step(1);
    endtask

    task automatic test_enable;
        EN = 1'b0; AA = 1'b1; step(2); AA = 1'b0;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL disabled_no_ring got=%b exp=%b", outs, 4'b0000);
        end
        EN = 1'b1; AA = 1'b1; step(1); AA = 1'b0;
        step(1);
        EN = 1'b0; step(1); EN = 1'b1;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL en_low_stops got=%b exp=%b", outs, 4'b0000);
        end
        step(1);
    endtask

    task automatic test_reset_mid_event;
        AA = 1'b1; step(1);
        SN = 1'b1; step(1); SN = 1'b0;
        checks++;
        if (outs !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset_snooze got=%b exp=%b", outs, 4'b0100);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", outs, 4'b0000);
        end
        step(2);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL held_reset got=%b exp=%b", outs, 4'b0000);
        end
        RST_N = 1'b1;
        step(1);
        checks++;
        if (outs !== 4'b1010) begin
            failures++;
            $display("FAIL refire_after_reset got=%b exp=%b", outs, 4'b1010);
        end
        AA = 1'b0;
        ST = 1'b1; step(1); ST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_beep();
        test_snooze();
        test_timeout();
        test_stop_and_snooze();
        test_snooze_limit();
        test_enable();
        test_reset_mid_event();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
